// File: rtl/fp_pkg.sv
// Shared FP writeback definitions: register-file geometry, queue entry layout
// and the round-robin source encoding.
package fp_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 1 << ADDR_WIDTH;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } fp_wb_entry_t;

    typedef enum logic {
        SRC_FPU = 1'b0,
        SRC_LD  = 1'b1
    } fp_wb_src_e;

endpackage

// File: rtl/fp_wb_rr_arbiter.sv
// Two-way round-robin arbiter between the FPU and the FP load unit.
// rr_ptr only moves when both sides compete and one of them is granted.
module fp_wb_rr_arbiter
    import fp_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic fpu_req,
    input  logic ld_req,
    output logic fpu_gnt,
    output logic ld_gnt
);

    fp_wb_src_e rr_ptr_q;
    fp_wb_src_e rr_ptr_d;

    always_comb begin
        fpu_gnt  = 1'b0;
        ld_gnt   = 1'b0;
        rr_ptr_d = rr_ptr_q;
        if (enable) begin
            if (fpu_req && ld_req) begin
                if (rr_ptr_q == SRC_FPU) begin
                    fpu_gnt  = 1'b1;
                    rr_ptr_d = SRC_LD;
                end else begin
                    ld_gnt   = 1'b1;
                    rr_ptr_d = SRC_FPU;
                end
            end else begin
                fpu_gnt = fpu_req;
                ld_gnt  = ld_req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= SRC_FPU;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/fp_writeback_queue.sv
// FIFO of FP results in front of the FP register file write port, with a
// per-register pending mask. Optional forwarding port under FP_WB_BYPASS_EN.
module fp_writeback_queue #(
    parameter int DATA_WIDTH = fp_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = fp_pkg::ADDR_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     fpu_valid,
    output logic                     fpu_ready,
    input  logic [ADDR_WIDTH-1:0]    fpu_addr,
    input  logic [DATA_WIDTH-1:0]    fpu_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [ADDR_WIDTH-1:0]    ld_addr,
    input  logic [DATA_WIDTH-1:0]    ld_data,
    input  logic                     drain_hold,
    output logic                     rf_write_En,
    output logic [ADDR_WIDTH-1:0]    rf_writeAddr,
    output logic [DATA_WIDTH-1:0]    rf_data,
    output logic [(1<<ADDR_WIDTH)-1:0] pending,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
`ifdef FP_WB_BYPASS_EN
    ,
    input  logic [ADDR_WIDTH-1:0]    byp_addr,
    output logic                     byp_hit,
    output logic [DATA_WIDTH-1:0]    byp_data
`endif
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = PTR_W + 1;

    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];

    logic                  fpu_gnt, ld_gnt, push, pop;
    logic [ADDR_WIDTH-1:0] push_addr;
    logic [DATA_WIDTH-1:0] push_data;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;

    // Gating with Rst_n keeps both readies low for the whole reset window.
    fp_wb_rr_arbiter u_arb (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .enable  (Rst_n & ~full),
        .fpu_req (fpu_valid),
        .ld_req  (ld_valid),
        .fpu_gnt (fpu_gnt),
        .ld_gnt  (ld_gnt)
    );

    assign fpu_ready = fpu_gnt;
    assign ld_ready  = ld_gnt;
    assign push      = fpu_gnt | ld_gnt;
    assign push_addr = fpu_gnt ? fpu_addr : ld_addr;
    assign push_data = fpu_gnt ? fpu_data : ld_data;

    assign pop          = ~empty & ~drain_hold;
    assign rf_write_En  = pop;
    assign rf_writeAddr = addr_q[head_q];
    assign rf_data      = data_q[head_q];

    // Push only happens when not full, so the tail slot never aliases the head being popped.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q]  = push_addr;
            data_d[tail_q]  = push_data;
            tail_d          = tail_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Payload needs no reset: it is only observed through the valid bits.
    always_ff @(posedge Clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                pending[addr_q[i]] = 1'b1;
            end
        end
    end

`ifdef FP_WB_BYPASS_EN
    // Walk oldest to youngest so the last match is the youngest value.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx      = '0;
        byp_hit  = 1'b0;
        byp_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if (valid_q[idx] && (addr_q[idx] == byp_addr)) begin
                byp_hit  = 1'b1;
                byp_data = data_q[idx];
            end
        end
    end
`endif

    initial assert (NUM_REGS == (1 << ADDR_WIDTH) && DEPTH >= 2 && (DEPTH & (DEPTH - 1)) == 0);

endmodule

// File: tb/tb_fp_writeback_queue.sv
// Self-checking bench for fp_writeback_queue: cycle model plus scoreboard,
// a vector table for arbitration/full behaviour, and directed corner sequences.
module tb_fp_writeback_queue;
    import fp_pkg::*;

    localparam int DW    = 64;
    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int NR    = 1 << AW;

    logic          Clk, Rst_n;
    logic          fpu_valid, ld_valid, drain_hold;
    logic          fpu_ready, ld_ready;
    logic [AW-1:0] fpu_addr, ld_addr, rf_writeAddr;
    logic [DW-1:0] fpu_data, ld_data, rf_data;
    logic          rf_write_En, empty, full;
    logic [NR-1:0] pending;
    logic [2:0]    count;
`ifdef FP_WB_BYPASS_EN
    logic [AW-1:0] byp_addr;
    logic          byp_hit;
    logic [DW-1:0] byp_data;
`endif

    fp_writeback_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .fpu_valid    (fpu_valid),
        .fpu_ready    (fpu_ready),
        .fpu_addr     (fpu_addr),
        .fpu_data     (fpu_data),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .drain_hold   (drain_hold),
        .rf_write_En  (rf_write_En),
        .rf_writeAddr (rf_writeAddr),
        .rf_data      (rf_data),
        .pending      (pending),
        .count        (count),
        .empty        (empty),
        .full         (full)
`ifdef FP_WB_BYPASS_EN
        ,
        .byp_addr     (byp_addr),
        .byp_hit      (byp_hit),
        .byp_data     (byp_data)
`endif
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    int dut_writes = 0;
    int max_cnt = 0;
    logic t6_active = 1'b0;

    fp_wb_entry_t exp_q[$];
    logic m_rr = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard / cycle model, evaluated on the inactive edge
    always @(negedge Clk) begin : monitor
        logic          e_we, e_fr, e_lr, elig;
        logic [NR-1:0] e_pend;
        logic          e_hit;
        logic [DW-1:0] e_bd;
        if (rf_write_En === 1'b1) dut_writes++;
        if (t6_active && int'(count) > max_cnt) max_cnt = int'(count);
        if (!Rst_n) begin
            exp_q.delete();
            m_rr = 1'b0;
            check("rst_count", 64'(count), 64'd0);
            check("rst_we", 64'(rf_write_En), 64'd0);
            check("rst_pending", 64'(pending), 64'd0);
            check("rst_empty", 64'(empty), 64'd1);
            check("rst_full", 64'(full), 64'd0);
            check("rst_fpu_ready", 64'(fpu_ready), 64'd0);
            check("rst_ld_ready", 64'(ld_ready), 64'd0);
        end else begin
            e_pend = '0;
            foreach (exp_q[i]) e_pend[exp_q[i].addr] = 1'b1;
            elig = exp_q.size() < DEPTH;
            e_fr = elig && fpu_valid && (!ld_valid || m_rr == 1'b0);
            e_lr = elig && ld_valid && (!fpu_valid || m_rr == 1'b1);
            e_we = (exp_q.size() != 0) && !drain_hold;
            check("sb_count", 64'(count), 64'(exp_q.size()));
            check("sb_empty", 64'(empty), 64'(exp_q.size() == 0));
            check("sb_full", 64'(full), 64'(exp_q.size() == DEPTH));
            check("sb_we", 64'(rf_write_En), 64'(e_we));
            check("sb_pending", 64'(pending), 64'(e_pend));
            check("sb_fpu_ready", 64'(fpu_ready), 64'(e_fr));
            check("sb_ld_ready", 64'(ld_ready), 64'(e_lr));
            if (e_we) begin
                check("sb_wr_addr", 64'(rf_writeAddr), 64'(exp_q[0].addr));
                check("sb_wr_data", rf_data, exp_q[0].data);
            end
`ifdef FP_WB_BYPASS_EN
            e_hit = 1'b0;
            e_bd  = '0;
            foreach (exp_q[i]) begin
                if (exp_q[i].addr == byp_addr) begin
                    e_hit = 1'b1;
                    e_bd  = exp_q[i].data;
                end
            end
            check("sb_byp_hit", 64'(byp_hit), 64'(e_hit));
            check("sb_byp_data", byp_data, e_bd);
`else
            e_hit = 1'b0;
            e_bd  = '0;
`endif
            if (e_we) void'(exp_q.pop_front());
            if (e_fr) exp_q.push_back('{addr: fpu_addr, data: fpu_data});
            else if (e_lr) exp_q.push_back('{addr: ld_addr, data: ld_data});
            if (elig && fpu_valid && ld_valid) m_rr = ~m_rr;
        end
    end

    // driver tasks: called at posedge+1, return at posedge+1 after the accepting edge
    task automatic fpu_push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int   waited;
        logic acc;
        waited = 0;
        acc    = 1'b0;
        fpu_valid = 1'b1;
        fpu_addr  = a;
        fpu_data  = d;
        while (!acc && waited < 50) begin
            @(negedge Clk);
            acc = fpu_ready;
            waited++;
        end
        @(posedge Clk);
        #1;
        fpu_valid = 1'b0;
        check("fpu_push_accepted", 64'(acc), 64'd1);
    endtask

    task automatic ld_push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int   waited;
        logic acc;
        waited = 0;
        acc    = 1'b0;
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        while (!acc && waited < 50) begin
            @(negedge Clk);
            acc = ld_ready;
            waited++;
        end
        @(posedge Clk);
        #1;
        ld_valid = 1'b0;
        check("ld_push_accepted", 64'(acc), 64'd1);
    endtask

    typedef struct {
        logic fv, lv, hold;
        logic fr, lr;
        int   cnt;
        logic full, we;
    } vec_t;

    vec_t vecs[12];

    initial begin : main
        int fk, lk, base, waited;
        logic [DW-1:0] val_a, val_b;

        // reset values for FPU-first arbitration, both sources requesting
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0};

        Rst_n = 1'b0;
        fpu_valid = 1'b0; ld_valid = 1'b0; drain_hold = 1'b0;
        fpu_addr = '0; fpu_data = '0; ld_addr = '0; ld_data = '0;
`ifdef FP_WB_BYPASS_EN
        byp_addr = '0;
`endif
        repeat (2) @(posedge Clk);
        #1;
        Rst_n = 1'b1;

        // 1: single push, one-cycle latency to the RF
        fpu_push(5'd3, 64'h4000_0000_0000_0000);
        @(negedge Clk);
        check("t1_we", 64'(rf_write_En), 64'd1);
        check("t1_addr", 64'(rf_writeAddr), 64'd3);
        check("t1_data", rf_data, 64'h4000_0000_0000_0000);
        check("t1_pend3", 64'(pending[3]), 64'd1);
        @(negedge Clk);
        check("t1_pend_clear", 64'(pending), 64'd0);
        check("t1_empty", 64'(empty), 64'd1);

        // 2/3: round-robin fill, full refusal, drain
        fk = 0;
        lk = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge Clk);
            #1;
            fpu_valid  = vecs[i].fv;
            ld_valid   = vecs[i].lv;
            drain_hold = vecs[i].hold;
            fpu_addr   = AW'(8 + fk);
            fpu_data   = 64'hF000_0000_0000_0000 | 64'(fk);
            ld_addr    = AW'(16 + lk);
            ld_data    = 64'hA000_0000_0000_0000 | 64'(lk);
            @(negedge Clk);
            check($sformatf("vec%0d_fpu_ready", i), 64'(fpu_ready), 64'(vecs[i].fr));
            check($sformatf("vec%0d_ld_ready", i), 64'(ld_ready), 64'(vecs[i].lr));
            check($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].cnt));
            check($sformatf("vec%0d_full", i), 64'(full), 64'(vecs[i].full));
            check($sformatf("vec%0d_we", i), 64'(rf_write_En), 64'(vecs[i].we));
            if (vecs[i].fr) fk++;
            if (vecs[i].lr) lk++;
        end

        // 4: two writes to the same register retire in order
        val_a = 64'h1111_2222_3333_4444;
        val_b = 64'h5555_6666_7777_8888;
        @(posedge Clk);
        #1;
        drain_hold = 1'b1;
`ifdef FP_WB_BYPASS_EN
        byp_addr = 5'd7;
`endif
        fpu_push(5'd7, val_a);
        fpu_push(5'd7, val_b);
        @(negedge Clk);
        check("t4_count", 64'(count), 64'd2);
        check("t4_pend7_held", 64'(pending[7]), 64'd1);
`ifdef FP_WB_BYPASS_EN
        check("t4_byp_hit", 64'(byp_hit), 64'd1);
        check("t4_byp_data", byp_data, val_b);
`endif
        @(posedge Clk);
        #1;
        drain_hold = 1'b0;
        @(negedge Clk);
        check("t4_wr_a", rf_data, val_a);
        check("t4_pend7_a", 64'(pending[7]), 64'd1);
        @(negedge Clk);
        check("t4_wr_b", rf_data, val_b);
        check("t4_pend7_b", 64'(pending[7]), 64'd1);
        @(negedge Clk);
        check("t4_pend7_clear", 64'(pending[7]), 64'd0);

        // 5: reset in the middle of a cycle with entries queued
        @(posedge Clk);
        #1;
        drain_hold = 1'b1;
        ld_push(5'd1, 64'h0000_0000_0000_0101);
        ld_push(5'd2, 64'h0000_0000_0000_0202);
        ld_push(5'd3, 64'h0000_0000_0000_0303);
        drain_hold = 1'b0;
        #1;
        check("t5_count_pre", 64'(count), 64'd3);
        check("t5_we_pre", 64'(rf_write_En), 64'd1);
        #1;
        Rst_n = 1'b0;
        #1;
        check("t5_count_rst", 64'(count), 64'd0);
        check("t5_we_rst", 64'(rf_write_En), 64'd0);
        check("t5_pend_rst", 64'(pending), 64'd0);
        @(negedge Clk);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        base = dut_writes;
        repeat (4) @(negedge Clk);
        check("t5_no_writes", 64'(dut_writes - base), 64'd0);

        // 6: back-to-back single-source stream with wrap-around
        @(posedge Clk);
        #1;
        base = dut_writes;
        t6_active = 1'b1;
        for (int i = 0; i < 20; i++) begin
`ifdef FP_WB_BYPASS_EN
            byp_addr = AW'($urandom_range(0, NR - 1));
`endif
            fpu_push(AW'($urandom_range(0, NR - 1)), {$urandom, $urandom});
        end
        waited = 0;
        while (empty !== 1'b1 && waited < 10) begin
            @(negedge Clk);
            waited++;
        end
        @(negedge Clk);
        t6_active = 1'b0;
        check("t6_drained", 64'(empty), 64'd1);
        check("t6_max_count", 64'(max_cnt), 64'd1);
        check("t6_writes", 64'(dut_writes - base), 64'd20);
        check("final_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
